// File: rtl/rpc_config_path_pkg.sv
// Shared configuration for the refresh/user command arbiter: FSM state type
// and default timing constants.
package rpc_config_path_pkg;

    typedef enum logic [1:0] {
        IDLE,
        GNT_USR,
        GNT_REF,
        RFC_WAIT
    } state_t;

    localparam int unsigned CMD_WIDTH_DEF    = 19;
    localparam int unsigned CNT_WIDTH_DEF    = 16;
    localparam int unsigned TRFC_CYCLES_DEF  = 32;
    localparam int unsigned MAX_POSTPONE_DEF = 64;

endpackage

// File: rtl/ref_cmd_arbiter_counter.sv
// Saturating up/down counter with synchronous clear and load.
module ref_cmd_arbiter_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             clr_i,
    input  logic             load_i,
    input  logic [WIDTH-1:0] load_val_i,
    input  logic             en_i,
    input  logic             down_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;

    // Clear beats load beats count; counting stops at 0 going down and all-ones going up.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else if (clr_i) begin
            cnt_q <= '0;
        end else if (load_i) begin
            cnt_q <= load_val_i;
        end else if (en_i) begin
            if (down_i) begin
                if (cnt_q != '0) begin
                    cnt_q <= cnt_q - 1'b1;
                end
            end else if (cnt_q != '1) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ref_cmd_arbiter.sv
// Arbiter between refresh requests and user commands towards the PHY command
// path, with a post-refresh blackout window.
// Optional feature: define REF_POSTPONE_EN to let user commands postpone a
// pending refresh until it has aged MAX_POSTPONE cycles; otherwise refresh
// has strict priority.
module ref_cmd_arbiter
    import rpc_config_path_pkg::*;
#(
    parameter int unsigned CMD_WIDTH    = CMD_WIDTH_DEF,
    parameter int unsigned CNT_WIDTH    = CNT_WIDTH_DEF,
    parameter int unsigned TRFC_CYCLES  = TRFC_CYCLES_DEF,
    parameter int unsigned MAX_POSTPONE = MAX_POSTPONE_DEF
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ref_valid_i,
    output logic                 ref_ready_o,
    input  logic [CMD_WIDTH-1:0] ref_cmd_i,
    input  logic                 usr_valid_i,
    output logic                 usr_ready_o,
    input  logic [CMD_WIDTH-1:0] usr_cmd_i,
    output logic                 cmd_valid_o,
    input  logic                 cmd_ready_i,
    output logic [CMD_WIDTH-1:0] cmd_o,
    output logic                 ref_busy_o
);

    localparam logic [CNT_WIDTH-1:0] GUARD_INIT =
        CNT_WIDTH'((TRFC_CYCLES == 0) ? 0 : TRFC_CYCLES - 1);

    state_t               state_q;
    state_t               state_d;
    logic [CMD_WIDTH-1:0] cmd_q;
    logic [CNT_WIDTH-1:0] guard;
    logic                 guard_load;
    logic                 ref_prio;

`ifdef REF_POSTPONE_EN
    logic [CNT_WIDTH-1:0] age;

    ref_cmd_arbiter_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_age_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (ref_ready_o),
        .load_i     (1'b0),
        .load_val_i ('0),
        .en_i       (ref_valid_i && !ref_ready_o),
        .down_i     (1'b0),
        .cnt_o      (age)
    );

    assign ref_prio = (32'(age) >= MAX_POSTPONE);
`else
    logic unused_postpone;

    assign ref_prio        = 1'b1;
    assign unused_postpone = |MAX_POSTPONE;
`endif

    ref_cmd_arbiter_counter #(
        .WIDTH (CNT_WIDTH)
    ) u_guard_cnt (
        .clk_i      (clk_i),
        .rst_ni     (rst_ni),
        .clr_i      (1'b0),
        .load_i     (guard_load),
        .load_val_i (GUARD_INIT),
        .en_i       (state_q == RFC_WAIT),
        .down_i     (1'b1),
        .cnt_o      (guard)
    );

    // State register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Capture the winning command word on the upstream handshake.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q <= '0;
        end else if (ref_ready_o) begin
            cmd_q <= ref_cmd_i;
        end else if (usr_ready_o) begin
            cmd_q <= usr_cmd_i;
        end
    end

    // Arbitration, next state and all outputs.
    always_comb begin
        state_d     = state_q;
        ref_ready_o = 1'b0;
        usr_ready_o = 1'b0;
        cmd_valid_o = 1'b0;
        cmd_o       = '0;
        ref_busy_o  = 1'b0;
        guard_load  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ref_valid_i && (!usr_valid_i || ref_prio)) begin
                    ref_ready_o = 1'b1;
                    state_d     = GNT_REF;
                end else if (usr_valid_i) begin
                    usr_ready_o = 1'b1;
                    state_d     = GNT_USR;
                end
            end
            GNT_USR: begin
                cmd_valid_o = 1'b1;
                cmd_o       = cmd_q;
                if (cmd_ready_i) begin
                    state_d = IDLE;
                end
            end
            GNT_REF: begin
                cmd_valid_o = 1'b1;
                cmd_o       = cmd_q;
                ref_busy_o  = 1'b1;
                if (cmd_ready_i) begin
                    guard_load = 1'b1;
                    state_d    = (TRFC_CYCLES == 0) ? IDLE : RFC_WAIT;
                end
            end
            RFC_WAIT: begin
                ref_busy_o = 1'b1;
                if (guard == '0) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule
